// File: rtl/out_img_streamer.sv
// Raster reader: drains w*h bytes from the destination buffer onto a valid/ready stream; first beat 3 clks after start, 1 beat/clk sustained.
// Backpressure is lossless via a 2-entry credit FIFO; STREAM_CHECKSUM_EN adds a mod-2^16 sum of accepted bytes.
module out_img_streamer #(
   parameter int AW = 19
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [15:0]   i_out_w,
   input  logic [15:0]   i_out_h,
   output logic          busy,
   output logic          done,
   output logic          mem_ren,
   output logic [AW-1:0] mem_raddr,
   input  logic [7:0]    mem_rdata,
   output logic          m_valid,
   input  logic          m_ready,
   output logic [7:0]    m_data,
   output logic          m_eol,
   output logic          m_last,
   output logic [31:0]   o_stall_cnt,
   output logic [15:0]   o_checksum
);

   typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_DONE} state_t;

   typedef struct packed {
      logic       eol;
      logic       last;
      logic [7:0] dat;
   } beat_t;

   state_t        r_state;
   logic          r_busy;
   logic          r_done;
   logic [15:0]   r_wm1;
   logic [15:0]   r_col;
   logic [AW-1:0] r_addr;
   logic [AW-1:0] r_last_addr;
   logic          r_pend;
   logic          r_pend_eol;
   logic          r_pend_last;
   beat_t         r_fifo [2];
   logic [1:0]    r_cnt;
   logic [31:0]   r_stall;

   logic          w_pop;
   logic [2:0]    w_occ;
   logic          w_issue;
   logic          w_eol;
   logic          w_last;
   logic          w_start_ok;
   logic          w_drained;
   logic          w_wr_hi;
   logic [AW-1:0] w_n;
   beat_t         w_new;

   assign w_pop      = (r_cnt != 2'd0) && m_ready;
   // Occupancy after this cycle's pop; counting the pop lets a read issue
   // in the same cycle a beat leaves, which is what sustains 1 beat/clk.
   assign w_occ      = {1'b0, r_cnt} + {2'b00, r_pend} - {2'b00, w_pop};
   assign w_issue    = (r_state == S_STREAM) && (w_occ < 3'd2);
   assign w_eol      = (r_col == r_wm1);
   assign w_last     = (r_addr == r_last_addr);
   assign w_start_ok = (i_out_w != 16'd0) && (i_out_h != 16'd0);
   assign w_drained  = !r_pend && (r_cnt == {1'b0, w_pop});
   assign w_wr_hi    = ((r_cnt - {1'b0, w_pop}) == 2'd1);
   assign w_n        = AW'(i_out_w) * AW'(i_out_h);
   assign w_new      = '{eol: r_pend_eol, last: r_pend_last, dat: mem_rdata};

   assign busy        = r_busy;
   assign done        = r_done;
   assign mem_ren     = w_issue;
   assign mem_raddr   = r_addr;
   assign m_valid     = (r_cnt != 2'd0);
   assign m_data      = r_fifo[0].dat;
   assign m_eol       = r_fifo[0].eol;
   assign m_last      = r_fifo[0].last;
   assign o_stall_cnt = r_stall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_wm1       <= 16'd0;
         r_col       <= 16'd0;
         r_addr      <= '0;
         r_last_addr <= '0;
         r_stall     <= 32'd0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_stall <= 32'd0;
                  if (w_start_ok) begin
                     r_state     <= S_STREAM;
                     r_busy      <= 1'b1;
                     r_wm1       <= i_out_w - 16'd1;
                     r_last_addr <= w_n - AW'(1);
                     r_addr      <= '0;
                     r_col       <= 16'd0;
                  end else begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end
               end
            end
            S_STREAM: begin
               if (w_issue) begin
                  r_addr <= r_addr + AW'(1);
                  r_col  <= w_eol ? 16'd0 : r_col + 16'd1;
                  if (w_last) r_state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (w_drained) begin
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
         if (m_valid && !m_ready && (r_stall != 32'hFFFF_FFFF))
            r_stall <= r_stall + 32'd1;
      end
   end

   // Read pipeline tags and the 2-entry FIFO; entry 0 is always the head.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pend      <= 1'b0;
         r_pend_eol  <= 1'b0;
         r_pend_last <= 1'b0;
         r_fifo[0]   <= '0;
         r_fifo[1]   <= '0;
         r_cnt       <= 2'd0;
      end else begin
         r_pend <= w_issue;
         if (w_issue) begin
            r_pend_eol  <= w_eol;
            r_pend_last <= w_last;
         end
         if (w_pop) r_fifo[0] <= r_fifo[1];
         if (r_pend) begin
            if (w_wr_hi) r_fifo[1] <= w_new;
            else         r_fifo[0] <= w_new;
         end
         r_cnt <= r_cnt + {1'b0, r_pend} - {1'b0, w_pop};
      end
   end

`ifdef STREAM_CHECKSUM_EN
   logic [15:0] r_cksum;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                        r_cksum <= 16'd0;
      else if (r_state == S_IDLE && start) r_cksum <= 16'd0;
      else if (w_pop)                    r_cksum <= r_cksum + {8'd0, m_data};
   end

   assign o_checksum = r_cksum;
`else
   assign o_checksum = 16'h0000;
`endif

endmodule

// File: tb/tb_out_img_streamer.sv
// Bench for out_img_streamer: a queue of expected beats built from w, h and the memory pattern, checked on every transfer.
module tb_out_img_streamer;

   localparam int AW = 19;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic [15:0]   i_out_w;
   logic [15:0]   i_out_h;
   logic          busy;
   logic          done;
   logic          mem_ren;
   logic [AW-1:0] mem_raddr;
   logic [7:0]    mem_rdata;
   logic          m_valid;
   logic          m_ready;
   logic [7:0]    m_data;
   logic          m_eol;
   logic          m_last;
   logic [31:0]   o_stall_cnt;
   logic [15:0]   o_checksum;

   out_img_streamer #(.AW(AW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .i_out_w(i_out_w), .i_out_h(i_out_h),
      .busy(busy), .done(done), .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_eol(m_eol), .m_last(m_last),
      .o_stall_cnt(o_stall_cnt), .o_checksum(o_checksum)
   );

   typedef struct packed {
      logic       eol;
      logic       last;
      logic [7:0] dat;
   } exp_t;

   exp_t        exp_q [$];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc = 0;
   int          t0 = 0;
   logic [7:0]  mem_base = 8'h00;
   logic [7:0]  mem_mul = 8'h01;
   int          rdy_mode = 0;
   int          rdy_phase = 0;
   int          beats, ren_cnt, val_cnt, first_ren, first_val, done_cnt, done_rel, last_beat;
   int          model_stall;
   logic [15:0] model_sum;
   logic        prev_hold = 1'b0;
   logic [10:0] prev_vec = '0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] mem_val(input logic [AW-1:0] a);
      return 8'(a) * mem_mul + mem_base;
   endfunction

   always @(posedge clk) if (mem_ren) mem_rdata <= mem_val(mem_raddr);

   always @(posedge clk) begin
      #1;
      rdy_phase++;
      case (rdy_mode)
         0:       m_ready = 1'b1;
         1:       m_ready = (rdy_phase % 3 == 0);
         default: m_ready = ($urandom_range(0, 2) != 0);
      endcase
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Per-cycle monitor: transfers against the expected queue, hold rule, stall model.
   always @(negedge clk) begin
      exp_t e;
      int   rel;
      if (!rst_n) begin
         prev_hold = 1'b0;
      end else begin
         rel = cyc - t0 + 1;
         if (mem_ren) begin
            ren_cnt++;
            if (first_ren < 0) first_ren = rel;
         end
         if (m_valid) begin
            val_cnt++;
            if (first_val < 0) first_val = rel;
         end
         if (prev_hold) chk("hold", {21'd0, m_valid, m_eol, m_last, m_data}, {21'd0, prev_vec});
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL extra_beat: got data %0h with no beat expected", m_data);
            end else begin
               e = exp_q.pop_front();
               chk($sformatf("beat%0d", beats), {22'd0, m_eol, m_last, m_data}, {22'd0, e.eol, e.last, e.dat});
               model_sum = model_sum + {8'd0, e.dat};
            end
            beats++;
            last_beat = rel;
         end
         if (m_valid && !m_ready) model_stall++;
         prev_hold = m_valid && !m_ready;
         prev_vec  = {1'b1, m_eol, m_last, m_data};
         if (done) begin
            done_cnt++;
            done_rel = rel;
         end
      end
   end

   task automatic launch(input int w, input int h);
      int n;
      n = w * h;
      exp_q.delete();
      for (int k = 0; k < n; k++)
         exp_q.push_back('{eol: (k % w == w - 1), last: (k == n - 1), dat: mem_val(AW'(k))});
      beats = 0; ren_cnt = 0; val_cnt = 0; first_ren = -1; first_val = -1;
      done_cnt = 0; done_rel = -1; last_beat = -1; model_stall = 0; model_sum = 16'd0;
      @(posedge clk); #1;
      start = 1'b1; i_out_w = 16'(w); i_out_h = 16'(h);
      @(posedge clk); #1;
      start = 1'b0;
      t0 = cyc;
   endtask

   task automatic do_run(input int w, input int h, input int restart_at);
      logic [15:0] exp_ck;
      launch(w, h);
      for (int k = 0; k < 3000 && done_cnt == 0; k++) begin
         @(posedge clk); #1;
         start = (restart_at != 0) && (cyc - t0 + 1 == restart_at);
         if (start) begin
            i_out_w = 16'd2;
            i_out_h = 16'd2;
         end
      end
      start = 1'b0;
      if (done_cnt == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL done_timeout: no done for %0dx%0d", w, h);
      end
      repeat (4) @(negedge clk);
      chk("left_in_queue", exp_q.size(), 0);
      chk("beat_count", beats, w * h);
      chk("done_pulses", done_cnt, 1);
      chk("busy_after", {31'd0, busy}, 0);
      chk("stall_cnt", o_stall_cnt, model_stall);
`ifdef STREAM_CHECKSUM_EN
      exp_ck = model_sum;
`else
      exp_ck = 16'h0000;
`endif
      chk("checksum", {16'd0, o_checksum}, {16'd0, exp_ck});
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_ctl"}, {21'd0, busy, done, mem_ren, m_valid, m_eol, m_last, 3'd0, 2'd0},
          32'd0);
      chk({nm, "_dat"}, {5'd0, mem_raddr, m_data}, 32'd0);
      chk({nm, "_stall"}, o_stall_cnt, 32'd0);
      chk({nm, "_ck"}, {16'd0, o_checksum}, 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; i_out_w = 16'd0; i_out_h = 16'd0; m_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk_zero("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Full-rate 4x3 with fixed latency pins.
      rdy_mode = 0; mem_base = 8'h00; mem_mul = 8'h01;
      do_run(4, 3, 0);
      chk("t1_first_ren", first_ren, 1);
      chk("t1_first_valid", first_val, 3);
      chk("t1_last_beat", last_beat, 14);
      chk("t1_done_rel", done_rel, 15);
      chk("t1_stall_lit", o_stall_cnt, 0);

      // Ready pattern 1,0,0.
      rdy_mode = 1;
      do_run(4, 3, 0);
      chk("t2_stall_nonzero", {31'd0, (o_stall_cnt != 0)}, 1);

      // Zero dimensions.
      rdy_mode = 0;
      do_run(0, 5, 0);
      chk("t3a_done_rel", done_rel, 1);
      chk("t3a_ren", ren_cnt, 0);
      chk("t3a_valid", val_cnt, 0);
      do_run(7, 0, 0);
      chk("t3b_done_rel", done_rel, 1);
      chk("t3b_ren", ren_cnt, 0);
      chk("t3b_valid", val_cnt, 0);

      // Restart attempt mid-run is ignored.
      do_run(4, 3, 5);
      chk("t4_beats_lit", beats, 12);

      // Async reset after 5 beats, then a fresh run.
      launch(4, 3);
      for (int k = 0; k < 200 && beats < 5; k++) begin
         @(posedge clk); #1;
      end
      chk("t5_reached5", beats, 5);
      rst_n = 1'b0;
      #1;
      chk_zero("t5_abort");
      exp_q.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      do_run(4, 3, 0);
      chk("t5_restart_first_valid", first_val, 3);

      // Checksum image: F0..FF sums to 0x0F78.
      mem_base = 8'hF0; mem_mul = 8'h01;
      do_run(8, 2, 0);
`ifdef STREAM_CHECKSUM_EN
      chk("t6_ck_lit", {16'd0, o_checksum}, 32'h0000_0F78);
`else
      chk("t6_ck_lit", {16'd0, o_checksum}, 32'h0000_0000);
`endif

      // Edge shapes and randomized runs.
      rdy_mode = 2;
      do_run(1, 1, 0);
      do_run(1, 4, 0);
      do_run(5, 1, 0);
      for (int r = 0; r < 8; r++) begin
         mem_base = 8'($urandom);
         mem_mul  = 8'($urandom) | 8'h01;
         rdy_mode = $urandom_range(0, 2);
         do_run($urandom_range(1, 7), $urandom_range(1, 5), 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
